// File: rtl/ysyx_22041752_axi_pkg.sv
// Shared definitions for the round-robin AXI arbiter: FSM states and the
// AXI4 burst/size/response encodings it drives or inspects.
package ysyx_22041752_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI size field for a full-width beat of dw bits
  function automatic logic [2:0] axiSize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/ysyx_22041752_rr_pick.sv
// Combinational round-robin selector: scans requests starting one past the
// last granted index, wrapping modulo NM, and reports the first one found.
module ysyx_22041752_rr_pick #(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Walk the NM candidates in priority order; the first requester wins
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 1; i <= NM; i++) begin
      cand = IW'((int'(last_i) + i) % NM);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041752_axiarb_rr.sv
// Round-robin arbiter funnelling NM simple request ports onto a single-beat
// AXI4 master, one transaction at a time.
// Optional: define YSYX_22041752_AXIARB_ERR_EN to latch a sticky error flag
// and the ID of the first non-OKAY response; otherwise err/err_id read 0.
module ysyx_22041752_axiarb_rr
  import ysyx_22041752_axi_pkg::*;
#(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NM-1:0]        m_en,
  input  logic [NM*DW/8-1:0]   m_wen,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_wdata,
  output logic [NM-1:0]        m_resp,
  output logic [DW-1:0]        m_rdata,
  output logic [IDW-1:0]       arid,
  output logic [AW-1:0]        araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [IDW-1:0]       rid,
  input  logic [DW-1:0]        rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [IDW-1:0]       awid,
  output logic [AW-1:0]        awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [DW-1:0]        wdata,
  output logic [DW/8-1:0]      wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [IDW-1:0]       bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic                 err,
  output logic [IDW-1:0]       err_id
);

  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awDone_q, awDone_d;
  logic            wDone_q, wDone_d;
  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  logic [IDW-1:0]  grantId;

  ysyx_22041752_rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req_i   (m_en),
    .last_i  (grant_q),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  assign grantId = IDW'(grant_q);
  assign m_rdata = rdata;
  assign arid    = grantId;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = axiSize(DW);
  assign arburst = AXI_BURST_INCR;
  assign awid    = grantId;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = axiSize(DW);
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;

  // Next-state, grant latching and handshake outputs for the transaction FSM
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    m_resp   = '0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d  = pickIdx;
          addr_d   = m_addr[pickIdx*AW +: AW];
          wen_d    = m_wen[pickIdx*SW +: SW];
          wdata_d  = m_wdata[pickIdx*DW +: DW];
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          state_d  = (m_wen[pickIdx*SW +: SW] == '0) ? RADDR : WREQ;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid && rid == grantId) begin
          m_resp[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      WREQ: begin
        awvalid  = !awDone_q;
        wvalid   = !wDone_q;
        awDone_d = awDone_q | (awvalid & awready);
        wDone_d  = wDone_q | (wvalid & wready);
        if (awDone_d && wDone_d) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid && bid == grantId) begin
          m_resp[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any in-flight transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= IW'(NM - 1);
      addr_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
    end
  end

`ifdef YSYX_22041752_AXIARB_ERR_EN
  logic           err_q, err_d;
  logic [IDW-1:0] errId_q, errId_d;
  logic           badBeat;

  // Flag an accepted, ID-matching R or B beat carrying a non-OKAY response
  always_comb begin
    badBeat = ((state_q == RDATA) && rvalid && (rid == grantId) && (rresp != AXI_RESP_OKAY)) ||
              ((state_q == WRESP) && bvalid && (bid == grantId) && (bresp != AXI_RESP_OKAY));
    err_d   = err_q;
    errId_d = errId_q;
    if (badBeat && !err_q) begin
      err_d   = 1'b1;
      errId_d = grantId;
    end
  end

  // Sticky error flag holding the ID of the first failure only
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q   <= 1'b0;
      errId_q <= '0;
    end else begin
      err_q   <= err_d;
      errId_q <= errId_d;
    end
  end

  assign err    = err_q;
  assign err_id = errId_q;
`else
  logic unusedResp;

  assign unusedResp = ^{rresp, bresp};
  assign err        = 1'b0;
  assign err_id     = '0;
`endif

endmodule
